// File: rtl/bpsk_bit_sync_if.sv
// rtl/bpsk_bit_sync_if.sv - sample stream in, bit decisions and timing status out
interface bpsk_bit_sync_if #(
    parameter int IN_W = 15,
    parameter int PH_W = 4
);
    logic signed [IN_W-1:0] din;
    logic                   din_ce;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   locked;
    logic [PH_W-1:0]        phase;

    modport master (
        output din,
        output din_ce,
        input  bit_out,
        input  bit_valid,
        input  locked,
        input  phase
    );

    modport slave (
        input  din,
        input  din_ce,
        output bit_out,
        output bit_valid,
        output locked,
        output phase
    );
endinterface

// File: rtl/bpsk_bit_sync.sv
// rtl/bpsk_bit_sync.sv - transition-tracking symbol sync, integrate-and-dump slicer, lock detector
// Optional differential decode of the sliced bit: define BIT_SYNC_DIFF_DECODE_EN.
module bpsk_bit_sync #(
    parameter int IN_W     = 15,
    parameter int SPS      = 16,
    parameter int ACC_W    = 19,
    parameter int TOL      = 1,
    parameter int LOCK_N   = 8,
    parameter int UNLOCK_N = 4
) (
    input  logic           clk,
    input  logic           rst,
    bpsk_bit_sync_if.slave sync_if
);
    localparam int PH_W = $clog2(SPS);
    localparam int GC_W = $clog2(LOCK_N + 1);
    localparam int BC_W = $clog2(UNLOCK_N + 1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_TRACK  = 1'b1;

    localparam logic [PH_W-1:0] PH_DUMP   = PH_W'(SPS - 1);
    localparam logic [PH_W-1:0] PH_HALF   = PH_W'(SPS / 2);
    localparam logic [PH_W-1:0] PH_TOL_LO = PH_W'(TOL);
    localparam logic [PH_W-1:0] PH_TOL_HI = PH_W'(SPS - TOL);

    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    prev_sign_q, prev_sign_d;
    logic                    adv_pend_q, adv_pend_d;
    logic                    ret_pend_q, ret_pend_d;
    logic                    hold_q, hold_d;
    logic [GC_W-1:0]         good_cnt_q, good_cnt_d;
    logic [BC_W-1:0]         bad_cnt_q, bad_cnt_d;
    logic [0:0]              state_q, state_d;
    logic                    bit_q, bit_d;
    logic                    valid_q, valid_d;
    logic                    locked_q, locked_d;
`ifdef BIT_SYNC_DIFF_DECODE_EN
    logic                    prev_dec_q, prev_dec_d;
`endif

    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    sgn;
    logic                    trans;
    logic                    dump;
    logic                    early;
    logic                    good;
    logic                    dec;

    assign din_ext = {{(ACC_W - IN_W){sync_if.din[IN_W-1]}}, sync_if.din};
    assign sum     = acc_q + din_ext;
    assign sgn     = sync_if.din[IN_W-1];
    assign trans   = sgn != prev_sign_q;
    assign dump    = phase_q == PH_DUMP;
    assign early   = phase_q < PH_HALF;
    // Transitions within TOL of the symbol edge, on either side, count toward lock.
    assign good    = (phase_q <= PH_TOL_LO) || ((TOL > 0) && (phase_q >= PH_TOL_HI));
    assign dec     = ~sum[ACC_W-1];

    always_comb begin
        phase_d     = phase_q;
        acc_d       = acc_q;
        prev_sign_d = prev_sign_q;
        adv_pend_d  = adv_pend_q;
        ret_pend_d  = ret_pend_q;
        hold_d      = hold_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        state_d     = state_q;
        bit_d       = bit_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
`ifdef BIT_SYNC_DIFF_DECODE_EN
        prev_dec_d  = prev_dec_q;
`endif

        if (sync_if.din_ce) begin
            prev_sign_d = sgn;

            if (dump) begin
                acc_d      = '0;
                valid_d    = 1'b1;
`ifdef BIT_SYNC_DIFF_DECODE_EN
                bit_d      = dec ^ prev_dec_q;
                prev_dec_d = dec;
`else
                bit_d      = dec;
`endif
                // Pending correction is consumed here; a transition on this
                // same sample re-arms below for the following dump.
                phase_d    = adv_pend_q ? PH_W'(1) : '0;
                hold_d     = ret_pend_q;
                adv_pend_d = 1'b0;
                ret_pend_d = 1'b0;
            end else begin
                acc_d = sum;
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            if (trans && (phase_q != '0)) begin
                if (early) begin
                    ret_pend_d = 1'b1;
                    adv_pend_d = 1'b0;
                end else begin
                    adv_pend_d = 1'b1;
                    ret_pend_d = 1'b0;
                end
            end

            if (trans) begin
                case (state_q)
                    ST_SEARCH: begin
                        if (good) begin
                            if (good_cnt_q >= GC_W'(LOCK_N - 1)) begin
                                good_cnt_d = GC_W'(LOCK_N);
                                bad_cnt_d  = '0;
                                state_d    = ST_TRACK;
                                locked_d   = 1'b1;
                            end else begin
                                good_cnt_d = good_cnt_q + GC_W'(1);
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                    default: begin
                        if (!good) begin
                            if (bad_cnt_q >= BC_W'(UNLOCK_N - 1)) begin
                                bad_cnt_d  = BC_W'(UNLOCK_N);
                                good_cnt_d = '0;
                                state_d    = ST_SEARCH;
                                locked_d   = 1'b0;
                            end else begin
                                bad_cnt_d = bad_cnt_q + BC_W'(1);
                            end
                        end else begin
                            bad_cnt_d = '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            acc_q       <= '0;
            prev_sign_q <= 1'b0;
            adv_pend_q  <= 1'b0;
            ret_pend_q  <= 1'b0;
            hold_q      <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            state_q     <= ST_SEARCH;
            bit_q       <= 1'b0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
`ifdef BIT_SYNC_DIFF_DECODE_EN
            prev_dec_q  <= 1'b0;
`endif
        end else begin
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            prev_sign_q <= prev_sign_d;
            adv_pend_q  <= adv_pend_d;
            ret_pend_q  <= ret_pend_d;
            hold_q      <= hold_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            state_q     <= state_d;
            bit_q       <= bit_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
`ifdef BIT_SYNC_DIFF_DECODE_EN
            prev_dec_q  <= prev_dec_d;
`endif
        end
    end

    assign sync_if.bit_out   = bit_q;
    assign sync_if.bit_valid = valid_q;
    assign sync_if.locked    = locked_q;
    assign sync_if.phase     = phase_q;
endmodule

// File: tb/tb_bpsk_bit_sync.sv
// tb/tb_bpsk_bit_sync.sv - directed vector bench for bpsk_bit_sync
module tb_bpsk_bit_sync;
    localparam int IN_W = 15;
    localparam int SPS  = 16;
    localparam int PH_W = 4;

    typedef struct {
        int val;
        bit exp_bit;
        bit exp_lock;
    } sym_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   last_ph = 0;
    int   idle_bad = 0;

    sym_vec_t aligned_tab[10];
    sym_vec_t sparse_tab[4];
    sym_vec_t dd_tab[10];

    bpsk_bit_sync_if #(.IN_W(IN_W), .PH_W(PH_W)) sync_if ();

    bpsk_bit_sync #(
        .IN_W(IN_W), .SPS(SPS), .ACC_W(19), .TOL(1), .LOCK_N(8), .UNLOCK_N(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sync_if(sync_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input int val);
        last_ph        = int'(sync_if.phase);
        sync_if.din    = IN_W'(val);
        sync_if.din_ce = 1'b1;
        @(posedge clk);
        #1;
        sync_if.din_ce = 1'b0;
    endtask

    task automatic strobe_sparse(input int val);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (sync_if.bit_valid) idle_bad++;
        end
        strobe(val);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        sync_if.din_ce = 1'b0;
        sync_if.din    = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int val_off(input int n, input int off);
        if (n < off) return 1000;
        return ((((n - off) / 16) % 2) == 0) ? -1000 : 1000;
    endfunction

    task automatic run_offset(input string tag, input int off, input int exp_dump[4],
                              input int exp_bit[4], input int exp_tp[4],
                              input int lock_at, input int conv_n);
        int dumps[$];
        int bits_q[$];
        int tps[$];
        int conv_bad;
        int alt_bad;
        int v;
        int prev_v;
        bit is_tr;
        conv_bad = 0;
        alt_bad  = 0;
        prev_v   = 1;
        do_reset();
        for (int n = 0; n < 220; n++) begin
            v     = val_off(n, off);
            is_tr = (v < 0) != (prev_v < 0);
            strobe(v);
            if (is_tr) begin
                if (tps.size() < 4) tps.push_back(last_ph);
                if (n >= conv_n && last_ph != 0) conv_bad++;
            end
            if (sync_if.bit_valid) begin
                dumps.push_back(n);
                bits_q.push_back(int'(sync_if.bit_out));
            end
            if (n == lock_at - 1) chk({tag, "_lock_pre"}, int'(sync_if.locked), 0);
            if (n == lock_at) chk({tag, "_lock_rise"}, int'(sync_if.locked), 1);
            prev_v = v;
        end
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_dump_idx"}, (i < dumps.size()) ? dumps[i] : -1, exp_dump[i]);
            chk({tag, "_bit"}, (i < bits_q.size()) ? bits_q[i] : -1, exp_bit[i]);
            chk({tag, "_trans_p"}, (i < tps.size()) ? tps[i] : -1, exp_tp[i]);
        end
        for (int i = 1; i < bits_q.size(); i++)
            if (bits_q[i] == bits_q[i-1]) alt_bad++;
        chk({tag, "_alternating"}, alt_bad, 0);
        chk({tag, "_conv_p0"}, conv_bad, 0);
    endtask

    initial begin
        int nvalid;
        int cur;
        int ntog;

        aligned_tab = '{'{1000, 1'b1, 1'b0}, '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b0},
                        '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b0}, '{-1000, 1'b0, 1'b0},
                        '{1000, 1'b1, 1'b0}, '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b1},
                        '{-1000, 1'b0, 1'b1}};
        sparse_tab  = '{'{-16384, 1'b0, 1'b0}, '{16383, 1'b1, 1'b0},
                        '{-16384, 1'b0, 1'b0}, '{16383, 1'b1, 1'b0}};
`ifdef BIT_SYNC_DIFF_DECODE_EN
        dd_tab = '{'{1000, 1'b1, 1'b0}, '{1000, 1'b0, 1'b0}, '{-1000, 1'b1, 1'b0},
                   '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b0},
                   '{-1000, 1'b0, 1'b0}, '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b0},
                   '{1000, 1'b0, 1'b0}, '{-1000, 1'b1, 1'b0}};
`else
        dd_tab = '{'{1000, 1'b1, 1'b0}, '{1000, 1'b1, 1'b0}, '{-1000, 1'b0, 1'b0},
                   '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b0},
                   '{-1000, 1'b0, 1'b0}, '{-1000, 1'b0, 1'b0}, '{1000, 1'b1, 1'b0},
                   '{1000, 1'b1, 1'b0}, '{-1000, 1'b0, 1'b0}};
`endif

        sync_if.din    = '0;
        sync_if.din_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bit_out", int'(sync_if.bit_out), 0);
        chk("rst_bit_valid", int'(sync_if.bit_valid), 0);
        chk("rst_locked", int'(sync_if.locked), 0);
        chk("rst_phase", int'(sync_if.phase), 0);
        rst = 1'b0;

        // aligned NRZ, transitions at p=0
        for (int s = 0; s < 10; s++) begin
            nvalid = 0;
            for (int k = 0; k < 16; k++) begin
                strobe(aligned_tab[s].val);
                if (k == 0 && s >= 1) chk("aligned_lock_edge", int'(sync_if.locked), int'(aligned_tab[s].exp_lock));
                if (k < 15) nvalid += int'(sync_if.bit_valid);
            end
            chk("aligned_dump_ph", last_ph, 15);
            chk("aligned_valid", int'(sync_if.bit_valid), 1);
            chk("aligned_bit", int'(sync_if.bit_out), int'(aligned_tab[s].exp_bit));
            chk("aligned_locked", int'(sync_if.locked), int'(aligned_tab[s].exp_lock));
            chk("aligned_phase_after", int'(sync_if.phase), 0);
            chk("aligned_midvalid", nvalid, 0);
        end

        // constant data while locked
        for (int s = 0; s < 20; s++) begin
            nvalid = 0;
            for (int k = 0; k < 16; k++) begin
                strobe(500);
                if (k < 15) nvalid += int'(sync_if.bit_valid);
            end
            chk("const_valid", int'(sync_if.bit_valid), 1);
            chk("const_bit", int'(sync_if.bit_out), 1);
            chk("const_locked", int'(sync_if.locked), 1);
            chk("const_midvalid", nvalid, 0);
        end

        // four mid-symbol transitions drop lock
        cur  = 500;
        ntog = 0;
        for (int i = 0; i < 200 && ntog < 4; i++) begin
            if (sync_if.phase == PH_W'(8)) begin
                cur = -cur;
                ntog++;
                strobe(cur);
                chk("unlock_step", int'(sync_if.locked), (ntog < 4) ? 1 : 0);
            end else begin
                strobe(cur);
            end
        end
        chk("unlock_toggles", ntog, 4);

        run_offset("late3", 3, '{15, 32, 49, 66}, '{0, 1, 0, 1}, '{3, 2, 1, 0}, 147, 51);
        run_offset("early12", 12, '{15, 30, 45, 60}, '{1, 0, 1, 0}, '{12, 13, 14, 15}, 172, 108);

        // sparse strobes, full-scale input
        do_reset();
        idle_bad = 0;
        for (int s = 0; s < 4; s++) begin
            nvalid = 0;
            for (int k = 0; k < 16; k++) begin
                strobe_sparse(sparse_tab[s].val);
                if (k < 15) nvalid += int'(sync_if.bit_valid);
            end
            chk("sparse_valid", int'(sync_if.bit_valid), 1);
            chk("sparse_bit", int'(sync_if.bit_out), int'(sparse_tab[s].exp_bit));
            chk("sparse_midvalid", nvalid, 0);
        end
        for (int k = 0; k < 7; k++) strobe_sparse(-16384);
        chk("sparse_idle_valid", idle_bad, 0);
        chk("pre_rst_phase", int'(sync_if.phase), 7);
        chk("pre_rst_bit", int'(sync_if.bit_out), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_bit_out", int'(sync_if.bit_out), 0);
        chk("midrst_bit_valid", int'(sync_if.bit_valid), 0);
        chk("midrst_locked", int'(sync_if.locked), 0);
        chk("midrst_phase", int'(sync_if.phase), 0);
        nvalid = 0;
        for (int k = 0; k < 16; k++) begin
            strobe_sparse((k < 8) ? 10000 : -9000);
            if (k < 15) nvalid += int'(sync_if.bit_valid);
        end
        chk("post_rst_midvalid", nvalid, 0);
        chk("post_rst_valid", int'(sync_if.bit_valid), 1);
        chk("post_rst_bit", int'(sync_if.bit_out), 1);

        // decision stream and its negation
        for (int s = 0; s < 10; s++) begin
            if (s == 0 || s == 5) do_reset();
            for (int k = 0; k < 16; k++) strobe(dd_tab[s].val);
            chk("dd_valid", int'(sync_if.bit_valid), 1);
            chk("dd_bit", int'(sync_if.bit_out), int'(dd_tab[s].exp_bit));
            chk("dd_locked", int'(sync_if.locked), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
